pmcc_loop_ctrl: RTL and testbench
=================================

// Module: pmcc_loop_ctrl
// PURPOSE
//  Hardware-loop sequencer for the PMC coprocessor. Holds the active loop (start address,
//  remaining passes) in a local register; saves outer loops to / restores them from the external
//  loop LIFO on nesting. Gives the PC logic a same-cycle branch decision at each loop-end instruction.
// PARAMETERS
//  ADDR_W      10  instruction address width (= pmcc_loop_t.start_address width)
//  ITER_W      14  iteration count width (= pmcc_loop_t.iterations width)
//  LIFO_DEPTH  10  capacity of the attached loop LIFO (saved outer loops)
// PORTS
//  clk             in   1        core clock; single clock domain
//  rst_n           in   1        asynchronous active-low reset
//  flush           in   1        synchronous soft clear (coprocessor restart)
//  loop_start      in   1        decoder: loop-setup instruction executes this cycle
//  loop_iterations in   ITER_W   pass count for new loop; 0 treated as 1
//  loop_body_addr  in   ADDR_W   address of first body instruction
//  loop_end        in   1        decoder: last body instruction executes this cycle
//  branch          out  1        PC must load branch_addr next (comb.)
//  branch_addr     out  ADDR_W   current loop start address (comb. from register)
//  stall           out  1        core must hold; high only in RESTORE
//  depth           out  4        active loops incl. current, 0..LIFO_DEPTH+1
//  overflow_err    out  1        sticky: loop_start with LIFO full
//  underflow_err   out  1        sticky: loop_end with no active loop
//  lifo_push       out  1        push strobe to LIFO
//  lifo_wdata      out  pmcc_loop_t  loop being saved
//  lifo_pop        out  1        pop strobe to LIFO
//  lifo_rdata      in   pmcc_loop_t  valid cycle after lifo_pop
//  lifo_full/empty in   1        LIFO status
// BEHAVIOUR
//  Reset (rst_n low) or flush: state IDLE, cur={0,0}, depth 0, both errors 0; branch/stall/push/pop 0.
//  FSM IDLE / ACTIVE / RESTORE.
//  IDLE: loop_start -> cur={loop_body_addr, max(iter,1)}, depth 1, ACTIVE. loop_end -> underflow_err.
//  ACTIVE, loop_start: if lifo_full -> overflow_err, request dropped, cur unchanged;
//   else lifo_push=1, lifo_wdata=cur, cur<=new loop, depth+1.
//  ACTIVE, loop_end: cur.iterations>1 -> branch=1 same cycle, branch_addr=cur.start_address,
//   iterations-1. ==1 -> loop done, no branch: lifo_empty -> IDLE, depth 0;
//   else lifo_pop=1, depth-1, -> RESTORE.
//  RESTORE (1 cycle): stall=1, cur<=lifo_rdata, -> ACTIVE. loop_start/loop_end ignored (core held).
//  loop_start & loop_end same cycle: loop_start served, loop_end dropped, underflow_err set.
//  Decrement never wraps: iterations stored >=1 always. depth saturates in invariant range, never wraps.
//  Strobes combinational, at most one of push/pop per cycle; never push on full, pop on empty.
//  flush leaves LIFO contents stale: parent drives LIFO pmcc_rst_n low in the same cycle.
//  rst_n mid-RESTORE: pending restore abandoned, IDLE.
// STRUCTURE
//  pmcc_pkg: pmcc_loop_t (reused), pmcc_loop_state_t enum, PMCC_LOOP_LIFO_DEPTH constant.
//  Flat module: FSM + cur register + depth counter + sticky error regs; no sub-module.
//  Parent instantiates pmcc_loop_lifo beside it.
// TESTING
//  Single loop body@0x010 iter=3 -> branch to 0x010 on first two loop_end, fall through 3rd, IDLE.
//  Nest 0x010/iter2 around 0x020/iter2 -> push {0x010,2}; inner done -> pop, stall 1 cycle, outer resumes.
//  11 nested loop_starts -> depth 11, 11th.. 12th start sets overflow_err, depth stays 11.
//  loop_end in IDLE -> underflow_err=1, no branch, no pop; cleared by flush.
//  iterations=0 -> body runs once, no branch, no pop.
//  rst_n low during RESTORE -> all outputs reset values, state IDLE next cycle.

Source files
------------

// File: rtl/pmcc_pkg.sv
// Shared types for the PMC coprocessor: loop descriptor, loop sequencer states and LIFO sizing.
package pmcc_pkg;

  localparam int unsigned PMCC_ADDR_W          = 10;
  localparam int unsigned PMCC_ITER_W          = 14;
  localparam int unsigned PMCC_LOOP_LIFO_DEPTH = 10;

  typedef struct packed {
    logic [PMCC_ADDR_W-1:0] start_address;
    logic [PMCC_ITER_W-1:0] iterations;
  } pmcc_loop_t;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StRestore
  } pmcc_loop_state_t;

endpackage

// File: rtl/pmcc_loop_ctrl.sv
// Hardware-loop sequencer: keeps the active loop locally, spills outer loops to an external LIFO
// and gives the PC logic a same-cycle branch decision at each loop-end instruction.
module pmcc_loop_ctrl
  import pmcc_pkg::*;
#(
  parameter int unsigned ADDR_W     = PMCC_ADDR_W,
  parameter int unsigned ITER_W     = PMCC_ITER_W,
  parameter int unsigned LIFO_DEPTH = PMCC_LOOP_LIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              loop_start,
  input  logic [ITER_W-1:0] loop_iterations,
  input  logic [ADDR_W-1:0] loop_body_addr,
  input  logic              loop_end,
  output logic              branch,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              stall,
  output logic [3:0]        depth,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              lifo_push,
  output pmcc_loop_t        lifo_wdata,
  output logic              lifo_pop,
  input  pmcc_loop_t        lifo_rdata,
  input  logic              lifo_full,
  input  logic              lifo_empty
);

  localparam logic [3:0]             DepthMax = 4'(LIFO_DEPTH + 1);
  localparam logic [PMCC_ITER_W-1:0] OnePass  = 1;

  pmcc_loop_state_t state_q;
  pmcc_loop_t       cur_q;
  pmcc_loop_t       new_loop;
  logic [3:0]       depth_q;
  logic             ovf_q, unf_q;
  logic             full_w, last_pass;

  // Depth check backs up lifo_full so the counter can never run past its range.
  assign full_w    = lifo_full | (depth_q >= DepthMax);
  assign last_pass = (cur_q.iterations <= OnePass);

  always_comb begin
    new_loop.start_address = loop_body_addr;
    new_loop.iterations    = (loop_iterations == '0) ? OnePass : loop_iterations;
  end

  always_comb begin
    branch    = 1'b0;
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    if (!flush && state_q == StActive) begin
      if (loop_start) begin
        lifo_push = ~full_w;
      end else if (loop_end) begin
        branch   = ~last_pass;
        lifo_pop = last_pass & ~lifo_empty;
      end
    end
  end

  assign stall         = ~flush & (state_q == StRestore);
  assign branch_addr   = cur_q.start_address;
  assign lifo_wdata    = cur_q;
  assign depth         = depth_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cur_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cur_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (loop_end) unf_q <= 1'b1;
          if (loop_start) begin
            cur_q   <= new_loop;
            depth_q <= 4'd1;
            state_q <= StActive;
          end
        end
        StActive: begin
          if (loop_start) begin
            // A coincident loop_end is lost; flag it.
            if (loop_end) unf_q <= 1'b1;
            if (full_w) begin
              ovf_q <= 1'b1;
            end else begin
              cur_q   <= new_loop;
              depth_q <= depth_q + 4'd1;
            end
          end else if (loop_end) begin
            if (!last_pass) begin
              cur_q.iterations <= cur_q.iterations - OnePass;
            end else if (lifo_empty) begin
              depth_q <= '0;
              state_q <= StIdle;
            end else begin
              depth_q <= (depth_q != '0) ? depth_q - 4'd1 : '0;
              state_q <= StRestore;
            end
          end
        end
        StRestore: begin
          cur_q   <= lifo_rdata;
          state_q <= StActive;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pmcc_loop_ctrl.sv
// Self-checking bench for pmcc_loop_ctrl: stack-based reference model plus directed scenarios.
module tb_pmcc_loop_ctrl;
  import pmcc_pkg::*;

  localparam int NLIFO = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        loop_start = 1'b0;
  logic        loop_end = 1'b0;
  logic [13:0] loop_iterations = '0;
  logic [9:0]  loop_body_addr = '0;
  logic        branch, stall, overflow_err, underflow_err;
  logic        lifo_push, lifo_pop, lifo_full, lifo_empty;
  logic [9:0]  branch_addr;
  logic [3:0]  depth;
  pmcc_loop_t  lifo_wdata, lifo_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pmcc_loop_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .loop_start     (loop_start),
    .loop_iterations(loop_iterations),
    .loop_body_addr (loop_body_addr),
    .loop_end       (loop_end),
    .branch         (branch),
    .branch_addr    (branch_addr),
    .stall          (stall),
    .depth          (depth),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err),
    .lifo_push      (lifo_push),
    .lifo_wdata     (lifo_wdata),
    .lifo_pop       (lifo_pop),
    .lifo_rdata     (lifo_rdata),
    .lifo_full      (lifo_full),
    .lifo_empty     (lifo_empty)
  );

  // External loop LIFO, cleared together with the controller.
  pmcc_loop_t lmem [NLIFO];
  int lcnt = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt       <= 0;
      lifo_rdata <= '0;
    end else if (flush) begin
      lcnt <= 0;
    end else if (lifo_push && lcnt < NLIFO) begin
      lmem[lcnt] <= lifo_wdata;
      lcnt       <= lcnt + 1;
    end else if (lifo_pop && lcnt > 0) begin
      lifo_rdata <= lmem[lcnt-1];
      lcnt       <= lcnt - 1;
    end
  end
  assign lifo_full  = (lcnt == NLIFO);
  assign lifo_empty = (lcnt == 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: current loop, stack of saved loops, one-cycle hold after a resume.
  pmcc_loop_t m_stack[$];
  pmcc_loop_t m_cur;
  bit m_active, m_hold, m_ovf, m_unf;

  task automatic m_reset();
    m_stack.delete();
    m_cur    = '0;
    m_active = 0;
    m_hold   = 0;
    m_ovf    = 0;
    m_unf    = 0;
  endtask

  always @(negedge clk) begin
    bit live, e_br, e_st, e_pu, e_po;
    int e_depth;
    pmcc_loop_t nl;
    if (!rst_n) m_reset();
    live    = rst_n && !flush;
    e_st    = live && m_hold;
    e_br    = live && !m_hold && m_active && !loop_start && loop_end && m_cur.iterations > 1;
    e_pu    = live && !m_hold && m_active && loop_start && m_stack.size() < NLIFO;
    e_po    = live && !m_hold && m_active && !loop_start && loop_end &&
              m_cur.iterations == 1 && m_stack.size() > 0;
    e_depth = m_active ? 1 + m_stack.size() : 0;
    chk("m_branch", 32'(branch), 32'(e_br));
    chk("m_stall", 32'(stall), 32'(e_st));
    chk("m_push", 32'(lifo_push), 32'(e_pu));
    chk("m_pop", 32'(lifo_pop), 32'(e_po));
    chk("m_depth", 32'(depth), 32'(e_depth));
    chk("m_overflow", 32'(overflow_err), 32'(m_ovf));
    chk("m_underflow", 32'(underflow_err), 32'(m_unf));
    if (e_br) chk("m_branch_addr", 32'(branch_addr), 32'(m_cur.start_address));
    if (e_pu) chk("m_wdata", 32'(lifo_wdata), 32'(m_cur));
    if (rst_n) begin
      if (flush) begin
        m_reset();
      end else if (m_hold) begin
        m_hold = 0;
      end else begin
        nl.start_address = loop_body_addr;
        nl.iterations    = (loop_iterations == 0) ? 14'd1 : loop_iterations;
        if (loop_start) begin
          if (loop_end) m_unf = 1;
          if (!m_active) begin
            m_cur    = nl;
            m_active = 1;
          end else if (m_stack.size() == NLIFO) begin
            m_ovf = 1;
          end else begin
            m_stack.push_back(m_cur);
            m_cur = nl;
          end
        end else if (loop_end) begin
          if (!m_active) m_unf = 1;
          else if (m_cur.iterations > 1) m_cur.iterations = m_cur.iterations - 14'd1;
          else if (m_stack.size() == 0) m_active = 0;
          else begin
            m_cur  = m_stack.pop_back();
            m_hold = 1;
          end
        end
      end
    end
  end

  task automatic drive(input bit s, input int it, input int a, input bit e);
    @(posedge clk);
    #1;
    flush           = 1'b0;
    loop_start      = s;
    loop_iterations = 14'(it);
    loop_body_addr  = 10'(a);
    loop_end        = e;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    flush      = 1'b1;
    loop_start = 1'b0;
    loop_end   = 1'b0;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_branch", 32'(branch), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    rst_n = 1'b1;

    // Single loop, three passes
    drive(1'b1, 3, 'h010, 1'b0);
    chk("t1_no_push", 32'(lifo_push), 32'd0);
    drive(1'b0, 0, 0, 1'b1);
    chk("t1_br1", 32'(branch), 32'd1);
    chk("t1_addr1", 32'(branch_addr), 32'h010);
    drive(1'b0, 0, 0, 1'b1);
    chk("t1_br2", 32'(branch), 32'd1);
    drive(1'b0, 0, 0, 1'b1);
    chk("t1_fall", 32'(branch), 32'd0);
    chk("t1_nopop", 32'(lifo_pop), 32'd0);
    idle();
    chk("t1_depth", 32'(depth), 32'd0);

    // Two-level nest
    drive(1'b1, 2, 'h010, 1'b0);
    drive(1'b1, 2, 'h020, 1'b0);
    chk("t2_push", 32'(lifo_push), 32'd1);
    chk("t2_wdata", 32'(lifo_wdata), 32'({10'h010, 14'd2}));
    drive(1'b0, 0, 0, 1'b1);
    chk("t2_inner_br", 32'(branch), 32'd1);
    chk("t2_inner_addr", 32'(branch_addr), 32'h020);
    drive(1'b0, 0, 0, 1'b1);
    chk("t2_inner_done", 32'(branch), 32'd0);
    chk("t2_pop", 32'(lifo_pop), 32'd1);
    idle();
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_depth", 32'(depth), 32'd1);
    idle();
    chk("t2_unstall", 32'(stall), 32'd0);
    drive(1'b0, 0, 0, 1'b1);
    chk("t2_outer_br", 32'(branch), 32'd1);
    chk("t2_outer_addr", 32'(branch_addr), 32'h010);
    drive(1'b0, 0, 0, 1'b1);
    chk("t2_outer_done", 32'(branch), 32'd0);
    idle();
    chk("t2_depth_end", 32'(depth), 32'd0);

    // Overflow: eleven nested loops fill the LIFO, the twelfth is refused
    for (int i = 0; i < 11; i++) drive(1'b1, 1, 16 * (i + 1), 1'b0);
    idle();
    chk("t3_depth11", 32'(depth), 32'd11);
    drive(1'b1, 1, 'h3f0, 1'b0);
    chk("t3_no_push", 32'(lifo_push), 32'd0);
    idle();
    chk("t3_ovf", 32'(overflow_err), 32'd1);
    chk("t3_depth_hold", 32'(depth), 32'd11);
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 0, 0, 1'b1);
      idle();
    end
    chk("t3_unwound", 32'(depth), 32'd0);
    do_flush();
    chk("t3_ovf_sticky", 32'(overflow_err), 32'd1);
    idle();
    chk("t3_ovf_clr", 32'(overflow_err), 32'd0);

    // loop_end with nothing active
    drive(1'b0, 0, 0, 1'b1);
    chk("t4_nobr", 32'(branch), 32'd0);
    chk("t4_nopop", 32'(lifo_pop), 32'd0);
    idle();
    chk("t4_unf", 32'(underflow_err), 32'd1);
    do_flush();
    idle();
    chk("t4_unf_clr", 32'(underflow_err), 32'd0);

    // Zero iterations run once
    drive(1'b1, 0, 'h030, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    chk("t5_nobr", 32'(branch), 32'd0);
    chk("t5_nopop", 32'(lifo_pop), 32'd0);
    idle();
    chk("t5_depth", 32'(depth), 32'd0);

    // Coincident start and end
    drive(1'b1, 5, 'h040, 1'b1);
    idle();
    chk("t6_unf", 32'(underflow_err), 32'd1);
    chk("t6_depth", 32'(depth), 32'd1);
    do_flush();
    idle();
    chk("t6_flushed", 32'(depth), 32'd0);

    // Reset while restoring
    drive(1'b1, 2, 'h010, 1'b0);
    drive(1'b1, 1, 'h020, 1'b0);
    drive(1'b0, 0, 0, 1'b1);
    chk("t7_pop", 32'(lifo_pop), 32'd1);
    @(posedge clk);
    #1;
    loop_end = 1'b0;
    chk("t7_restore", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_stall", 32'(stall), 32'd0);
    chk("t7_rst_depth", 32'(depth), 32'd0);
    chk("t7_rst_branch", 32'(branch), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    chk("t7_idle_stall", 32'(stall), 32'd0);
    chk("t7_idle_depth", 32'(depth), 32'd0);

    repeat (3) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
